vx_tb_reset_sequencer: RTL and testbench

//  Parametrised testbench bring-up sequencer; replaces hand-driven per-block resets and loader/DCR strobes.

---
 rtl/vx_tb_reset_sequencer_if.sv | 31 +++
 rtl/vx_tb_reset_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_vx_tb_reset_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_tb_reset_sequencer_if.sv
// Loader handshake and DCR write bus between the bring-up sequencer and the
// testbench top. The sequencer drives the master side.
interface vx_tb_reset_sequencer_if #(
    parameter int DCR_ADDR_W = 12,
    parameter int DCR_DATA_W = 32
);
    logic                  start_mem_loader;
    logic                  load_mem;
    logic                  mem_loader_done;
    logic                  dcr_write_valid;
    logic [DCR_ADDR_W-1:0] dcr_write_addr;
    logic [DCR_DATA_W-1:0] dcr_write_data;

    modport master (
        output start_mem_loader,
        output load_mem,
        output dcr_write_valid,
        output dcr_write_addr,
        output dcr_write_data,
        input  mem_loader_done
    );

    modport slave (
        input  start_mem_loader,
        input  load_mem,
        input  dcr_write_valid,
        input  dcr_write_addr,
        input  dcr_write_data,
        output mem_loader_done
    );
endinterface

// File: rtl/vx_tb_reset_sequencer.sv
// Testbench bring-up sequencer: holds all reset domains, releases the
// pre-load group one by one, runs the memory-loader handshake, issues the
// DCR write table, then releases the remaining domains. All outputs are
// registered; the bus interface widths must match DCR_ADDR_W/DCR_DATA_W.
module vx_tb_reset_sequencer #(
    parameter int NUM_DOMAINS      = 7,
    parameter int PRE_LOAD_DOMAINS = 3,
    parameter int HOLD_CYCLES      = 4,
    parameter int STAGE_GAP        = 2,
    parameter int NUM_DCR          = 2,
    parameter int DCR_ADDR_W       = 12,
    parameter int DCR_DATA_W       = 32,
    parameter int LOAD_TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   restart,
    input  logic                   load_en,
    // With NUM_DCR=0 the tables keep a single (unused) entry so they never collapse to zero width.
    input  logic [(NUM_DCR > 0 ? NUM_DCR : 1)*DCR_ADDR_W-1:0] dcr_tbl_addr,
    input  logic [(NUM_DCR > 0 ? NUM_DCR : 1)*DCR_DATA_W-1:0] dcr_tbl_data,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   seq_done,
    output logic                   load_timeout_err,
    output logic [2:0]             seq_state,
    vx_tb_reset_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_HOLD     = 3'd0,
        S_REL_PRE  = 3'd1,
        S_LOAD     = 3'd2,
        S_DCR      = 3'd3,
        S_REL_POST = 3'd4,
        S_DONE     = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    state_t                  r_state, w_state, w_target;
    logic [31:0]             r_cnt, w_cnt;
    logic [31:0]             r_idx, w_idx;
    logic [NUM_DOMAINS-1:0]  r_dom, w_dom;
    logic                    r_start, w_start;
    logic                    r_load_mem, w_load_mem;
    logic                    r_dcr_valid, w_dcr_valid;
    logic [DCR_ADDR_W-1:0]   r_dcr_addr, w_dcr_addr;
    logic [DCR_DATA_W-1:0]   r_dcr_data, w_dcr_data;
    logic                    r_done, w_done;
    logic                    r_err, w_err;
    logic                    w_enter;
    logic                    w_rel_en;
    logic [31:0]             w_rel_idx;
    logic                    w_sel_en;
    logic [31:0]             w_sel_idx;
    logic [31:0]             w_stage_end;

    // Next-state and next-output decode; stage entries resolve empty-stage skips.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        w_state     = r_state;
        w_target    = r_state;
        w_enter     = 1'b0;
        w_cnt       = r_cnt + 32'd1;
        w_idx       = r_idx;
        w_dom       = r_dom;
        w_start     = 1'b0;
        w_load_mem  = r_load_mem;
        w_dcr_valid = 1'b0;
        w_dcr_addr  = '0;
        w_dcr_data  = '0;
        w_done      = r_done;
        w_err       = r_err;
        w_rel_en    = 1'b0;
        w_rel_idx   = r_idx;
        w_sel_en    = 1'b0;
        w_sel_idx   = r_idx;
        w_stage_end = (r_state == S_REL_PRE) ? 32'(PRE_LOAD_DOMAINS) : 32'(NUM_DOMAINS);

        case (r_state)
            S_HOLD: begin
                if (r_cnt == 32'(HOLD_CYCLES - 1)) begin
                    w_enter  = 1'b1;
                    w_target = S_REL_PRE;
                end
            end
            S_REL_PRE, S_REL_POST: begin
                if (r_cnt == 32'(STAGE_GAP - 1)) begin
                    if (r_idx < w_stage_end) begin
                        w_rel_en = 1'b1;
                        w_idx    = r_idx + 32'd1;
                        w_cnt    = '0;
                    end else begin
                        w_enter  = 1'b1;
                        w_target = (r_state == S_REL_PRE) ? S_LOAD : S_DONE;
                    end
                end
            end
            S_LOAD: begin
                // load_mem low means this is the idle pass-through LOAD cycle.
                if (!r_load_mem || bus.mem_loader_done) begin
                    w_enter  = 1'b1;
                    w_target = S_DCR;
                end else if (LOAD_TIMEOUT != 0 && r_cnt == 32'(LOAD_TIMEOUT - 1)) begin
                    w_state    = S_ERROR;
                    w_err      = 1'b1;
                    w_load_mem = 1'b0;
                end
            end
            S_DCR: begin
                if (r_idx < 32'(NUM_DCR)) begin
                    w_dcr_valid = 1'b1;
                    w_sel_en    = 1'b1;
                    w_idx       = r_idx + 32'd1;
                end else begin
                    w_enter  = 1'b1;
                    w_target = S_REL_POST;
                end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    w_state = S_HOLD;
                    w_cnt   = '0;
                    w_idx   = '0;
                    w_dom   = '1;
                    w_done  = 1'b0;
                    w_err   = 1'b0;
                end
            end
            default: begin
                w_state = S_HOLD;
            end
        endcase

        if (w_enter) begin
            w_load_mem = 1'b0;
            if (w_target == S_REL_PRE && PRE_LOAD_DOMAINS == 0) w_target = S_LOAD;
            if (w_target == S_DCR && NUM_DCR == 0) w_target = S_REL_POST;
            if (w_target == S_REL_POST && PRE_LOAD_DOMAINS >= NUM_DOMAINS) w_target = S_DONE;
            w_state = w_target;
            w_cnt   = '0;
            case (w_target)
                S_REL_PRE: begin
                    w_rel_en  = 1'b1;
                    w_rel_idx = '0;
                    w_idx     = 32'd1;
                end
                S_LOAD: begin
                    w_start    = load_en;
                    w_load_mem = load_en;
                end
                S_DCR: begin
                    w_dcr_valid = 1'b1;
                    w_sel_en    = 1'b1;
                    w_sel_idx   = '0;
                    w_idx       = 32'd1;
                end
                S_REL_POST: begin
                    w_rel_en  = 1'b1;
                    w_rel_idx = 32'(PRE_LOAD_DOMAINS);
                    w_idx     = 32'(PRE_LOAD_DOMAINS + 1);
                end
                S_DONE: begin
                    w_done = 1'b1;
                end
                default: begin
                end
            endcase
        end

        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (w_rel_en && 32'(i) == w_rel_idx) w_dom[i] = 1'b0;
        end
        for (int j = 0; j < NUM_DCR; j++) begin
            if (w_sel_en && 32'(j) == w_sel_idx) begin
                w_dcr_addr = dcr_tbl_addr[j*DCR_ADDR_W +: DCR_ADDR_W];
                w_dcr_data = dcr_tbl_data[j*DCR_DATA_W +: DCR_DATA_W];
            end
        end
    end

    // State and registered outputs; synchronous reset aborts any stage in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state     <= S_HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_dom       <= '1;
            r_start     <= 1'b0;
            r_load_mem  <= 1'b0;
            r_dcr_valid <= 1'b0;
            r_dcr_addr  <= '0;
            r_dcr_data  <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_idx       <= w_idx;
            r_dom       <= w_dom;
            r_start     <= w_start;
            r_load_mem  <= w_load_mem;
            r_dcr_valid <= w_dcr_valid;
            r_dcr_addr  <= w_dcr_addr;
            r_dcr_data  <= w_dcr_data;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    assign domain_reset         = r_dom;
    assign seq_done             = r_done;
    assign load_timeout_err     = r_err;
    assign seq_state            = r_state;
    assign bus.start_mem_loader = r_start;
    assign bus.load_mem         = r_load_mem;
    assign bus.dcr_write_valid  = r_dcr_valid;
    assign bus.dcr_write_addr   = r_dcr_addr;
    assign bus.dcr_write_data   = r_dcr_data;

endmodule

// File: tb/tb_vx_tb_reset_sequencer.sv
// Directed bench for the bring-up sequencer. Three instances cover the
// default configuration, a short load timeout, and a 3-entry DCR table
// with no pre-load domains.
module tb_vx_tb_reset_sequencer;

    typedef struct packed {
        logic [6:0]  dom;
        logic [2:0]  state;
        logic        start;
        logic        load;
        logic        valid;
        logic [11:0] addr;
        logic [31:0] data;
        logic        done;
        logic        err;
    } snap_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: defaults
    logic        rst_a, restart_a, load_en_a;
    logic [6:0]  dom_a;
    logic        done_a, err_a;
    logic [2:0]  state_a;
    logic [23:0] tbl_addr_a = {12'h202, 12'h101};
    logic [63:0] tbl_data_a = {32'hBEEF_0002, 32'hDEAD_0001};
    vx_tb_reset_sequencer_if #(.DCR_ADDR_W(12), .DCR_DATA_W(32)) if_a ();

    vx_tb_reset_sequencer u_a (
        .clk(clk), .reset(rst_a), .restart(restart_a), .load_en(load_en_a),
        .dcr_tbl_addr(tbl_addr_a), .dcr_tbl_data(tbl_data_a),
        .domain_reset(dom_a), .seq_done(done_a), .load_timeout_err(err_a),
        .seq_state(state_a), .bus(if_a)
    );

    // Instance B: short load timeout
    logic        rst_b, restart_b, load_en_b;
    logic [6:0]  dom_b;
    logic        done_b, err_b;
    logic [2:0]  state_b;
    logic [23:0] tbl_addr_b = {12'h3A4, 12'h3A0};
    logic [63:0] tbl_data_b = {32'h5A5A_0000, 32'h0000_00A5};
    vx_tb_reset_sequencer_if #(.DCR_ADDR_W(12), .DCR_DATA_W(32)) if_b ();

    vx_tb_reset_sequencer #(.LOAD_TIMEOUT(8)) u_b (
        .clk(clk), .reset(rst_b), .restart(restart_b), .load_en(load_en_b),
        .dcr_tbl_addr(tbl_addr_b), .dcr_tbl_data(tbl_data_b),
        .domain_reset(dom_b), .seq_done(done_b), .load_timeout_err(err_b),
        .seq_state(state_b), .bus(if_b)
    );

    // Instance C: three DCR entries, nothing released before load
    logic        rst_c, restart_c, load_en_c;
    logic [6:0]  dom_c;
    logic        done_c, err_c;
    logic [2:0]  state_c;
    logic [35:0] tbl_addr_c = {12'h030, 12'h020, 12'h010};
    logic [95:0] tbl_data_c = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    vx_tb_reset_sequencer_if #(.DCR_ADDR_W(12), .DCR_DATA_W(32)) if_c ();

    vx_tb_reset_sequencer #(.NUM_DCR(3), .PRE_LOAD_DOMAINS(0)) u_c (
        .clk(clk), .reset(rst_c), .restart(restart_c), .load_en(load_en_c),
        .dcr_tbl_addr(tbl_addr_c), .dcr_tbl_data(tbl_data_c),
        .domain_reset(dom_c), .seq_done(done_c), .load_timeout_err(err_c),
        .seq_state(state_c), .bus(if_c)
    );

    logic [11:0] exp_addr_a [2] = '{12'h101, 12'h202};
    logic [31:0] exp_data_a [2] = '{32'hDEAD_0001, 32'hBEEF_0002};
    logic [11:0] exp_addr_b [2] = '{12'h3A0, 12'h3A4};
    logic [31:0] exp_data_b [2] = '{32'h0000_00A5, 32'h5A5A_0000};
    logic [11:0] exp_addr_c [3] = '{12'h010, 12'h020, 12'h030};
    logic [31:0] exp_data_c [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic snap_t snap_a();
        return '{dom_a, state_a, if_a.start_mem_loader, if_a.load_mem, if_a.dcr_write_valid,
                 if_a.dcr_write_addr, if_a.dcr_write_data, done_a, err_a};
    endfunction

    function automatic snap_t snap_b();
        return '{dom_b, state_b, if_b.start_mem_loader, if_b.load_mem, if_b.dcr_write_valid,
                 if_b.dcr_write_addr, if_b.dcr_write_data, done_b, err_b};
    endfunction

    function automatic snap_t snap_c();
        return '{dom_c, state_c, if_c.start_mem_loader, if_c.load_mem, if_c.dcr_write_valid,
                 if_c.dcr_write_addr, if_c.dcr_write_data, done_c, err_c};
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        s     = '0;
        s.dom = 7'h7F;
        return s;
    endfunction

    task automatic test_reset();
        snap_t got;
        rst_a = 1'b1;
        tick();
        tick();
        got = snap_a();
        n_checks++;
        if (got !== reset_snap()) begin
            n_fail++;
            $display("FAIL reset_values got=%h exp=%h", got, reset_snap());
        end
    endtask

    // Load with loader done at cycle 20
    task automatic test_load_done();
        snap_t exp, got;
        int rel [7] = '{4, 6, 8, 23, 25, 27, 29};
        rst_a = 1'b1; load_en_a = 1'b1; if_a.mem_loader_done = 1'b0;
        tick();
        rst_a = 1'b0;
        for (int c = 0; c <= 33; c++) begin
            if_a.mem_loader_done = (c == 20);
            exp = '0;
            for (int d = 0; d < 7; d++) exp.dom[d] = (c < rel[d]);
            exp.state = c < 4 ? 3'd0 : c < 10 ? 3'd1 : c < 21 ? 3'd2 : c < 23 ? 3'd3 : c < 31 ? 3'd4 : 3'd5;
            exp.start = (c == 10);
            exp.load  = (c >= 10 && c <= 20);
            if (c == 21 || c == 22) begin
                exp.valid = 1'b1;
                exp.addr  = exp_addr_a[c-21];
                exp.data  = exp_data_a[c-21];
            end
            exp.done = (c >= 31);
            got = snap_a();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL load_done cycle=%0d got=%h exp=%h", c, got, exp);
            end
            tick();
        end
        if_a.mem_loader_done = 1'b0;
    endtask

    // Restart from DONE behaves like reset, then HOLD runs its full length
    task automatic test_restart_done();
        snap_t got;
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
        got = snap_a();
        n_checks++;
        if (got !== reset_snap()) begin
            n_fail++;
            $display("FAIL restart_done got=%h exp=%h", got, reset_snap());
        end
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (state_a !== 3'd0 || dom_a !== 7'h7F) begin
            n_fail++;
            $display("FAIL restart_hold_c3 state=%0d dom=%h exp state=0 dom=7f", state_a, dom_a);
        end
        tick();
        n_checks++;
        if (state_a !== 3'd1 || dom_a !== 7'h7E) begin
            n_fail++;
            $display("FAIL restart_rel_c4 state=%0d dom=%h exp state=1 dom=7e", state_a, dom_a);
        end
    endtask

    // load_en=0: one idle LOAD cycle, no pulse
    task automatic test_no_load();
        snap_t exp, got;
        int rel [7] = '{4, 6, 8, 13, 15, 17, 19};
        rst_a = 1'b1; load_en_a = 1'b0; if_a.mem_loader_done = 1'b0;
        tick();
        rst_a = 1'b0;
        for (int c = 0; c <= 23; c++) begin
            exp = '0;
            for (int d = 0; d < 7; d++) exp.dom[d] = (c < rel[d]);
            exp.state = c < 4 ? 3'd0 : c < 10 ? 3'd1 : c == 10 ? 3'd2 : c < 13 ? 3'd3 : c < 21 ? 3'd4 : 3'd5;
            if (c == 11 || c == 12) begin
                exp.valid = 1'b1;
                exp.addr  = exp_addr_a[c-11];
                exp.data  = exp_data_a[c-11];
            end
            exp.done = (c >= 21);
            got = snap_a();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL no_load cycle=%0d got=%h exp=%h", c, got, exp);
            end
            tick();
        end
    endtask

    // Reset asserted in LOAD, then the sequence reruns from cycle 0
    task automatic test_reset_mid();
        snap_t got;
        rst_a = 1'b1; load_en_a = 1'b1; if_a.mem_loader_done = 1'b0;
        tick();
        rst_a = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        n_checks++;
        if (state_a !== 3'd2 || if_a.load_mem !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre state=%0d load_mem=%b exp state=2 load_mem=1", state_a, if_a.load_mem);
        end
        rst_a = 1'b1;
        tick();
        got = snap_a();
        n_checks++;
        if (got !== reset_snap()) begin
            n_fail++;
            $display("FAIL reset_mid_abort got=%h exp=%h", got, reset_snap());
        end
        rst_a = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        n_checks++;
        if (state_a !== 3'd2 || if_a.start_mem_loader !== 1'b1 || dom_a !== 7'h78 || if_a.load_mem !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_rerun state=%0d start=%b dom=%h load=%b exp 2 1 78 1",
                     state_a, if_a.start_mem_loader, dom_a, if_a.load_mem);
        end
        tick();
        n_checks++;
        if (if_a.start_mem_loader !== 1'b0 || if_a.load_mem !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pulse start=%b load=%b exp 0 1", if_a.start_mem_loader, if_a.load_mem);
        end
    endtask

    // Timeout after 8 LOAD cycles, error sticky, restart clears it
    task automatic test_timeout();
        snap_t exp, got;
        rst_b = 1'b1; load_en_b = 1'b1; if_b.mem_loader_done = 1'b0;
        tick();
        rst_b = 1'b0;
        for (int c = 0; c <= 22; c++) begin
            exp = '0;
            exp.dom   = {4'hF, (c < 8), (c < 6), (c < 4)};
            exp.state = c < 4 ? 3'd0 : c < 10 ? 3'd1 : c < 18 ? 3'd2 : 3'd6;
            exp.start = (c == 10);
            exp.load  = (c >= 10 && c <= 17);
            exp.err   = (c >= 18);
            got = snap_b();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL timeout cycle=%0d got=%h exp=%h", c, got, exp);
            end
            tick();
        end
        restart_b = 1'b1;
        tick();
        restart_b = 1'b0;
        got = snap_b();
        n_checks++;
        if (got !== reset_snap()) begin
            n_fail++;
            $display("FAIL timeout_restart got=%h exp=%h", got, reset_snap());
        end
    endtask

    // Done in the last allowed LOAD cycle beats the timeout; early done is ignored
    task automatic test_done_last_cycle();
        snap_t exp, got;
        int rel [7] = '{4, 6, 8, 20, 22, 24, 26};
        rst_b = 1'b1; load_en_b = 1'b1; if_b.mem_loader_done = 1'b0;
        tick();
        rst_b = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            if_b.mem_loader_done = (c == 5 || c == 6 || c == 17);
            exp = '0;
            for (int d = 0; d < 7; d++) exp.dom[d] = (c < rel[d]);
            exp.state = c < 4 ? 3'd0 : c < 10 ? 3'd1 : c < 18 ? 3'd2 : c < 20 ? 3'd3 : 3'd4;
            exp.start = (c == 10);
            exp.load  = (c >= 10 && c <= 17);
            if (c == 18 || c == 19) begin
                exp.valid = 1'b1;
                exp.addr  = exp_addr_b[c-18];
                exp.data  = exp_data_b[c-18];
            end
            got = snap_b();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL done_last cycle=%0d got=%h exp=%h", c, got, exp);
            end
            tick();
        end
        if_b.mem_loader_done = 1'b0;
    endtask

    // No pre-load stage, 3 DCR entries, restart ignored in REL_POST
    task automatic test_skip_pre_dcr3();
        snap_t exp, got;
        int rel [7] = '{8, 10, 12, 14, 16, 18, 20};
        rst_c = 1'b1; load_en_c = 1'b0; if_c.mem_loader_done = 1'b0;
        tick();
        rst_c = 1'b0;
        for (int c = 0; c <= 24; c++) begin
            restart_c = (c == 9);
            exp = '0;
            for (int d = 0; d < 7; d++) exp.dom[d] = (c < rel[d]);
            exp.state = c < 4 ? 3'd0 : c == 4 ? 3'd2 : c < 8 ? 3'd3 : c < 22 ? 3'd4 : 3'd5;
            if (c >= 5 && c <= 7) begin
                exp.valid = 1'b1;
                exp.addr  = exp_addr_c[c-5];
                exp.data  = exp_data_c[c-5];
            end
            exp.done = (c >= 22);
            got = snap_c();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL skip_pre_dcr3 cycle=%0d got=%h exp=%h", c, got, exp);
            end
            tick();
        end
        restart_c = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; restart_a = 1'b0; load_en_a = 1'b1; if_a.mem_loader_done = 1'b0;
        rst_b = 1'b1; restart_b = 1'b0; load_en_b = 1'b1; if_b.mem_loader_done = 1'b0;
        rst_c = 1'b1; restart_c = 1'b0; load_en_c = 1'b0; if_c.mem_loader_done = 1'b0;
        test_reset();
        test_load_done();
        test_restart_done();
        test_no_load();
        test_reset_mid();
        test_timeout();
        test_done_last_cycle();
        test_skip_pre_dcr3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
